// File: rtl/timing_pkg.sv
// Shared phase encoding and default timing widths for the cycle timing
// sequencer and the state-machine decoder that supplies its length codes.
package timing_pkg;

    typedef enum logic [1:0] {
        PH_ADDR = 2'd0,
        PH_OP   = 2'd1,
        PH_INT  = 2'd2
    } phase_t;

    localparam int TIME_W_DEF     = 3;
    localparam int INT_CYCLES_DEF = 7;

endpackage

// File: rtl/cycle_timing_sequencer_phase_counter.sv
// Per-phase time index: advances while enabled, returns to 0 at the end of a
// phase, and reports when the index has reached or passed the phase length.
module phase_counter #(
    parameter int TIME_W = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              clr,
    input  logic [TIME_W-1:0] len,
    output logic [TIME_W-1:0] count,
    output logic              term
);

    // >= rather than == so a length that drops below the index ends the phase.
    assign term = (count >= len);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (en) begin
            if (clr || term) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cycle_timing_sequencer.sv
// ADDR -> OP -> (INT) -> ADDR phase sequencer with live length codes, a
// ready stall, and sync / last-cycle / instruction-done / interrupt-ack strobes.
module cycle_timing_sequencer
    import timing_pkg::*;
#(
    parameter int TIME_W     = TIME_W_DEF,
    parameter int INT_CYCLES = INT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ready,
    input  logic [TIME_W-1:0] addr_len,
    input  logic [TIME_W-1:0] op_len,
    input  logic              int_req,
    output logic [TIME_W-1:0] time_out,
    output logic [1:0]        phase,
    output logic              sync,
    output logic              last_cycle,
    output logic              instr_done,
    output logic              int_ack
);

    localparam logic [TIME_W-1:0] INT_LAST = TIME_W'(INT_CYCLES - 1);

    phase_t            state;
    phase_t            state_nx;
    logic [TIME_W-1:0] cur_len;
    logic              illegal;

    assign illegal = (state == phase_t'(2'b11));

    always_comb begin
        cur_len = addr_len;
        case (state)
            PH_ADDR: cur_len = addr_len;
            PH_OP:   cur_len = op_len;
            PH_INT:  cur_len = INT_LAST;
            default: cur_len = addr_len;
        endcase
    end

    phase_counter #(
        .TIME_W (TIME_W)
    ) u_counter (
        .clk   (clk),
        .nrst  (nrst),
        .en    (ready),
        .clr   (illegal),
        .len   (cur_len),
        .count (time_out),
        .term  (last_cycle)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= PH_ADDR;
        end else begin
            state <= state_nx;
        end
    end

    // int_req is only looked at on the OP-phase boundary that actually advances.
    always_comb begin
        state_nx = state;
        if (ready && (last_cycle || illegal)) begin
            case (state)
                PH_ADDR: state_nx = PH_OP;
                PH_OP:   state_nx = int_req ? PH_INT : PH_ADDR;
                PH_INT:  state_nx = PH_ADDR;
                default: state_nx = PH_ADDR;
            endcase
        end
    end

    assign phase      = state;
    assign sync       = (state == PH_ADDR) && (time_out == '0);
    assign instr_done = ready && (state == PH_OP)  && last_cycle;
    assign int_ack    = ready && (state == PH_INT) && last_cycle;

endmodule
